// File: rtl/ram_arbiter_if.sv
`timescale 1ns/1ps
// ram_arbiter_if
// Purpose: one master's request/response bundle toward the ram arbiter.
// Signals:
//   req       : access request (held until gnt)
//   we        : 1 = write, 0 = read
//   lock      : keep ownership after this transfer
//   data_type : access size/type forwarded to the ram
//   addr      : byte address
//   wdata     : write data
//   gnt       : transfer accepted this cycle
//   rvalid    : one-cycle pulse, rdata valid
//   rdata     : registered read data, held until the next read
// Modports: master (requester side), slave (arbiter side).
interface ram_arbiter_if;
    logic        req;
    logic        we;
    logic        lock;
    logic [1:0]  data_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, lock, data_type, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, data_type, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// ram_arbiter
// Purpose: shares one data ram between two masters (m0 = core load/store,
// m1 = loader/DMA/debug). One owner at a time; ties are broken by m0
// priority or round-robin, a tenure is bounded to MAX_HOLD transfers while
// the other master waits, and lock keeps ownership for atomic sequences.
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-high reset
//   m0, m1         : master bundles (ram_arbiter_if.slave)
//   ram_write/read : ram strobes, only during an accepted transfer
//   ram_data_type, ram_address, ram_data_out : ram command from the owner
//   ram_data_in    : ram read data, valid in the same cycle as ram_read
module ram_arbiter #(
    parameter bit PRIORITY_M0 = 1'b0,
    parameter int MAX_HOLD    = 8
) (
    input  logic                clk,
    input  logic                reset,
    ram_arbiter_if.slave        m0,
    ram_arbiter_if.slave        m1,
    output logic                ram_write,
    output logic                ram_read,
    output logic [1:0]          ram_data_type,
    output logic [31:0]         ram_address,
    output logic [31:0]         ram_data_out,
    input  logic [31:0]         ram_data_in
);
    localparam int             CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_SAT = CW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_last;
    logic           w_last_next;
    logic [CW-1:0]  r_hold_cnt;
    logic [CW-1:0]  w_hold_cnt_next;
    logic           r_rvalid0;
    logic           r_rvalid1;
    logic [31:0]    r_rdata0;
    logic [31:0]    r_rdata1;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_hold_ok;

    assign w_gnt0 = (r_state == OWN0) && m0.req;
    assign w_gnt1 = (r_state == OWN1) && m1.req;

    // True while one more transfer still fits in the current tenure.
    assign w_hold_ok = (int'(r_hold_cnt) + 1) < MAX_HOLD;

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = r_rvalid0;
    assign m1.rvalid = r_rvalid1;
    assign m0.rdata  = r_rdata0;
    assign m1.rdata  = r_rdata1;

    // State, last-owner and tenure counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_last     <= w_last_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    // Next-state, last-owner and tenure counter logic.
    always_comb begin
        w_state_next    = r_state;
        w_last_next     = r_last;
        w_hold_cnt_next = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (m0.req && m1.req) begin
                    // Round-robin favours whichever master did not own last.
                    w_state_next = (PRIORITY_M0 || r_last) ? OWN0 : OWN1;
                end else if (m0.req) begin
                    w_state_next = OWN0;
                end else if (m1.req) begin
                    w_state_next = OWN1;
                end
            end
            OWN0: begin
                if (m0.lock) begin
                    w_state_next = OWN0;
                end else if (m0.req && (!m1.req || w_hold_ok)) begin
                    w_state_next = OWN0;
                end else if (m1.req) begin
                    w_state_next = OWN1;
                end else begin
                    w_state_next = IDLE;
                end
                if (w_state_next != OWN0) begin
                    w_last_next = 1'b0;
                end
            end
            OWN1: begin
                if (m1.lock) begin
                    w_state_next = OWN1;
                end else if (m1.req && (!m0.req || w_hold_ok)) begin
                    w_state_next = OWN1;
                end else if (m0.req) begin
                    w_state_next = OWN0;
                end else begin
                    w_state_next = IDLE;
                end
                if (w_state_next != OWN1) begin
                    w_last_next = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A new tenure starts from zero; within a tenure count accepted
        // transfers, saturating so a long locked sequence cannot wrap.
        if (w_state_next != r_state) begin
            w_hold_cnt_next = '0;
        end else if ((w_gnt0 || w_gnt1) && (r_hold_cnt != HOLD_SAT)) begin
            w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
    end

    // RAM command mux: the owner's fields drive the ram, strobes only on grant.
    always_comb begin
        ram_write     = 1'b0;
        ram_read      = 1'b0;
        ram_data_type = 2'b00;
        ram_address   = 32'd0;
        ram_data_out  = 32'd0;
        case (r_state)
            OWN0: begin
                ram_write     = w_gnt0 && m0.we;
                ram_read      = w_gnt0 && !m0.we;
                ram_data_type = m0.data_type;
                ram_address   = m0.addr;
                ram_data_out  = m0.wdata;
            end
            OWN1: begin
                ram_write     = w_gnt1 && m1.we;
                ram_read      = w_gnt1 && !m1.we;
                ram_data_type = m1.data_type;
                ram_address   = m1.addr;
                ram_data_out  = m1.wdata;
            end
            default: begin
                ram_write = 1'b0;
            end
        endcase
    end

    // Read return: capture ram data on an accepted read, pulse rvalid next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= 32'd0;
            r_rdata1  <= 32'd0;
        end else begin
            r_rvalid0 <= w_gnt0 && !m0.we;
            r_rvalid1 <= w_gnt1 && !m1.we;
            if (w_gnt0 && !m0.we) begin
                r_rdata0 <= ram_data_in;
            end
            if (w_gnt1 && !m1.we) begin
                r_rdata1 <= ram_data_in;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
// Two arbiters (round-robin and m0-priority, MAX_HOLD=4) receive the same
// master stimulus; each is compared every cycle against a behavioural model
// of ownership, tenure and read return, with a small ram behind each.
module tb_ram_arbiter;
    localparam int MAXH = 4;

    logic        clk;
    logic        reset;

    logic        d_req  [2];
    logic        d_we   [2];
    logic        d_lock [2];
    logic [1:0]  d_ty   [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wd   [2];

    logic        o_gnt [4];
    logic        o_rv  [4];
    logic [31:0] o_rd  [4];

    logic        ram_we_o [2];
    logic        ram_rd_o [2];
    logic [1:0]  ram_ty_o [2];
    logic [31:0] ram_ad_o [2];
    logic [31:0] ram_do_o [2];
    logic [31:0] ram_di   [2];
    logic [31:0] env_mem  [2][64];

    int          checks = 0;
    int          errors = 0;

    // Reference model state, per arbiter instance (0 = round-robin, 1 = m0 priority).
    int          m_own  [2];     // -1 = nobody owns the ram
    int          m_last [2];
    int          m_cnt  [2];     // transfers accepted in the current tenure
    logic        m_rv   [2][2];
    logic [31:0] m_rd   [2][2];
    logic [31:0] m_mem  [2][64];

    ram_arbiter_if ifc [4] ();

    for (genvar gi = 0; gi < 4; gi++) begin : g_if
        assign ifc[gi].req       = d_req[gi % 2];
        assign ifc[gi].we        = d_we[gi % 2];
        assign ifc[gi].lock      = d_lock[gi % 2];
        assign ifc[gi].data_type = d_ty[gi % 2];
        assign ifc[gi].addr      = d_addr[gi % 2];
        assign ifc[gi].wdata     = d_wd[gi % 2];
        assign o_gnt[gi]         = ifc[gi].gnt;
        assign o_rv[gi]          = ifc[gi].rvalid;
        assign o_rd[gi]          = ifc[gi].rdata;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ram
        assign ram_di[gi] = env_mem[gi][ram_ad_o[gi][7:2]];
    end

    ram_arbiter #(.PRIORITY_M0(1'b0), .MAX_HOLD(MAXH)) u_rr (
        .clk(clk), .reset(reset), .m0(ifc[0]), .m1(ifc[1]),
        .ram_write(ram_we_o[0]), .ram_read(ram_rd_o[0]),
        .ram_data_type(ram_ty_o[0]), .ram_address(ram_ad_o[0]),
        .ram_data_out(ram_do_o[0]), .ram_data_in(ram_di[0])
    );

    ram_arbiter #(.PRIORITY_M0(1'b1), .MAX_HOLD(MAXH)) u_pr (
        .clk(clk), .reset(reset), .m0(ifc[2]), .m1(ifc[3]),
        .ram_write(ram_we_o[1]), .ram_read(ram_rd_o[1]),
        .ram_data_type(ram_ty_o[1]), .ram_address(ram_ad_o[1]),
        .ram_data_out(ram_do_o[1]), .ram_data_in(ram_di[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_last[k] = 1;
            m_cnt[k]  = 0;
            for (int j = 0; j < 2; j++) begin
                m_rv[k][j] = 1'b0;
                m_rd[k][j] = 32'd0;
            end
        end
    endtask

    // Compare every output of both arbiters with what the model predicts.
    task automatic chk_all();
        for (int k = 0; k < 2; k++) begin
            logic        eg [2];
            logic        e_wr, e_rd;
            logic [1:0]  e_ty;
            logic [31:0] e_ad, e_do;
            int          own;
            own  = m_own[k];
            e_wr = 1'b0;
            e_rd = 1'b0;
            e_ty = 2'b00;
            e_ad = 32'd0;
            e_do = 32'd0;
            for (int j = 0; j < 2; j++) eg[j] = (own == j) && d_req[j];
            if (own >= 0) begin
                e_ty = d_ty[own];
                e_ad = d_addr[own];
                e_do = d_wd[own];
                e_wr = eg[own] && d_we[own];
                e_rd = eg[own] && !d_we[own];
            end
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("i%0d_m%0d_gnt", k, j), 32'(o_gnt[2*k+j]), 32'(eg[j]));
                chk($sformatf("i%0d_m%0d_rvalid", k, j), 32'(o_rv[2*k+j]), 32'(m_rv[k][j]));
                chk($sformatf("i%0d_m%0d_rdata", k, j), o_rd[2*k+j], m_rd[k][j]);
            end
            chk($sformatf("i%0d_ram_write", k), 32'(ram_we_o[k]), 32'(e_wr));
            chk($sformatf("i%0d_ram_read", k), 32'(ram_rd_o[k]), 32'(e_rd));
            chk($sformatf("i%0d_ram_type", k), 32'(ram_ty_o[k]), 32'(e_ty));
            chk($sformatf("i%0d_ram_addr", k), ram_ad_o[k], e_ad);
            chk($sformatf("i%0d_ram_wdata", k), ram_do_o[k], e_do);
            if (ram_we_o[k] === 1'b1) env_mem[k][ram_ad_o[k][7:2]] = ram_do_o[k];
        end
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic eg [2];
            int   own, nxt, x, y, t;
            own = m_own[k];
            for (int j = 0; j < 2; j++) begin
                eg[j] = (own == j) && d_req[j];
                m_rv[k][j] = eg[j] && !d_we[j];
                if (eg[j] && !d_we[j]) m_rd[k][j] = m_mem[k][d_addr[j][7:2]];
                if (eg[j] && d_we[j])  m_mem[k][d_addr[j][7:2]] = d_wd[j];
            end
            t = 0;
            if (own < 0) begin
                if (d_req[0] && d_req[1]) nxt = (k == 1) ? 0 : 1 - m_last[k];
                else if (d_req[0])        nxt = 0;
                else if (d_req[1])        nxt = 1;
                else                      nxt = -1;
            end else begin
                x = own;
                y = 1 - own;
                t = m_cnt[k] + (eg[x] ? 1 : 0);
                if (d_lock[x])                             nxt = x;
                else if (d_req[x] && (!d_req[y] || t < MAXH)) nxt = x;
                else if (d_req[y])                         nxt = y;
                else                                       nxt = -1;
            end
            if (nxt != own) begin
                if (own >= 0) m_last[k] = own;
                m_cnt[k] = 0;
            end else begin
                m_cnt[k] = t;
            end
            m_own[k] = nxt;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        chk_all();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic set_m(input int j, input logic req, input logic we, input logic lock,
                         input logic [1:0] ty, input logic [31:0] addr, input logic [31:0] wd);
        d_req[j]  = req;
        d_we[j]   = we;
        d_lock[j] = lock;
        d_ty[j]   = ty;
        d_addr[j] = addr;
        d_wd[j]   = wd;
    endtask

    task automatic idle_all();
        set_m(0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        set_m(1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
    endtask

    initial begin
        int n0 [2];
        int first1 [2];
        logic [31:0] v;

        reset = 1'b1;
        idle_all();
        model_reset();
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            for (int k = 0; k < 2; k++) begin
                env_mem[k][i] = v;
                m_mem[k][i]   = v;
            end
        end
        @(posedge clk);
        #1;
        chk_all();
        reset = 1'b0;
        step();

        // Single read from IDLE: gnt one cycle after req, rvalid one after that.
        for (int k = 0; k < 2; k++) begin
            env_mem[k][4] = 32'hDEADBEEF;
            m_mem[k][4]   = 32'hDEADBEEF;
        end
        set_m(0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h10, 32'd0);
        settle();
        for (int k = 0; k < 2; k++) chk($sformatf("rd_i%0d_gnt_n", k), 32'(o_gnt[2*k]), 32'd0);
        tick();
        settle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_i%0d_gnt_n1", k), 32'(o_gnt[2*k]), 32'd1);
            chk($sformatf("rd_i%0d_ram_read", k), 32'(ram_rd_o[k]), 32'd1);
            chk($sformatf("rd_i%0d_ram_addr", k), ram_ad_o[k], 32'h10);
        end
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        settle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_i%0d_rvalid_n2", k), 32'(o_rv[2*k]), 32'd1);
            chk($sformatf("rd_i%0d_rdata_n2", k), o_rd[2*k], 32'hDEADBEEF);
        end
        tick();
        step();

        // Reset in the middle of a granted read.
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h24, 32'd0);
        step();
        settle();
        reset = 1'b1;
        #1;
        model_reset();
        chk_all();
        @(posedge clk);
        #1;
        idle_all();
        reset = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) chk($sformatf("rst_i%0d_no_rvalid", k), 32'(o_rv[2*k]), 32'd0);
        tick();

        // Ties: from reset m0 wins both; after m0 owned, round-robin picks m1.
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h40, 32'd0);
        set_m(1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h44, 32'd0);
        step();
        settle();
        chk("tie_rr_first_m0", 32'(o_gnt[0]), 32'd1);
        chk("tie_pr_first_m0", 32'(o_gnt[2]), 32'd1);
        tick();
        idle_all();
        step();
        set_m(0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h48, 32'd0);
        set_m(1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h4C, 32'd0);
        step();
        settle();
        chk("tie_rr_second_m1", 32'(o_gnt[1]), 32'd1);
        chk("tie_pr_second_m0", 32'(o_gnt[2]), 32'd1);
        tick();
        idle_all();
        step();
        step();

        // Tenure limit: m0 streams writes while m1 waits.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h80, $urandom);
        set_m(1, 1'b1, 1'b1, 1'b0, 2'b10, 32'hC0, 32'h12345678);
        for (int k = 0; k < 2; k++) begin
            n0[k]     = 0;
            first1[k] = -1;
        end
        for (int c = 0; c < 6; c++) begin
            settle();
            for (int k = 0; k < 2; k++) begin
                if (o_gnt[2*k] === 1'b1 && first1[k] < 0) n0[k]++;
                if (o_gnt[2*k+1] === 1'b1 && first1[k] < 0) first1[k] = c;
            end
            tick();
            set_m(0, 1'b1, 1'b1, 1'b0, 2'b10, 32'($urandom_range(32, 47)) << 2, $urandom);
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("hold_i%0d_m0_gnts", k), 32'(n0[k]), 32'd4);
            chk($sformatf("hold_i%0d_m1_gnt_cycle", k), 32'(first1[k]), 32'd5);
        end
        idle_all();
        step();
        step();

        // Lock: m1 keeps the ram while idle; m0 waits until the lock drops.
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b1, 2'b10, 32'h08, 32'h0BADF00D);
        step();
        settle();
        for (int k = 0; k < 2; k++) chk($sformatf("lock_i%0d_m1_gnt", k), 32'(o_gnt[2*k+1]), 32'd1);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        set_m(0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h30, 32'd0);
        for (int c = 0; c < 3; c++) begin
            settle();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("lock_i%0d_c%0d_m0_gnt", k, c), 32'(o_gnt[2*k]), 32'd0);
                chk($sformatf("lock_i%0d_c%0d_strobes", k, c),
                    32'({ram_we_o[k], ram_rd_o[k]}), 32'd0);
            end
            tick();
        end
        d_lock[1] = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) chk($sformatf("unlock_i%0d_m0_wait", k), 32'(o_gnt[2*k]), 32'd0);
        tick();
        settle();
        for (int k = 0; k < 2; k++) chk($sformatf("unlock_i%0d_m0_gnt", k), 32'(o_gnt[2*k]), 32'd1);
        tick();
        idle_all();
        step();
        step();

        // Mixed traffic: m0 writes, m1 reads the same word back.
        set_m(0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h20, 32'hA5A5A5A5);
        step();
        settle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mix_i%0d_ram_write", k), 32'(ram_we_o[k]), 32'd1);
            chk($sformatf("mix_i%0d_ram_wdata", k), ram_do_o[k], 32'hA5A5A5A5);
        end
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        set_m(1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h20, 32'd0);
        step();
        settle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mix_i%0d_m1_gnt", k), 32'(o_gnt[2*k+1]), 32'd1);
            chk($sformatf("mix_i%0d_m0_no_rvalid", k), 32'(o_rv[2*k]), 32'd0);
        end
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        settle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mix_i%0d_m1_rvalid", k), 32'(o_rv[2*k+1]), 32'd1);
            chk($sformatf("mix_i%0d_m1_rdata", k), o_rd[2*k+1], 32'hA5A5A5A5);
        end
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < 2; j++) begin
                set_m(j, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                      32'($urandom_range(0, 63)) << 2, $urandom);
            end
            step();
        end
        idle_all();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
